// File: rtl/generic_bus_if.sv
// Generic single-word memory bus between a requester (cpu) and a memory (slave).
// A transfer completes in the cycle where ren is high and busy is low.
interface generic_bus_if;
  logic        ren;
  logic        wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        busy;
  logic [3:0]  byte_en;

  modport cpu (
    output ren, wen, addr, wdata, byte_en,
    input  rdata, busy
  );

  modport slave (
    input  ren, wen, addr, wdata, byte_en,
    output rdata, busy
  );
endinterface

// File: rtl/fetch_queue.sv
// Halfword instruction fetch queue: prefetches aligned words from the I$ and
// presents one RV32C or 32-bit instruction per cycle at any halfword alignment.
module fetch_queue #(
  parameter int          DEPTH_HW = 8,
  parameter logic [31:0] RESET_PC = 32'h0000_0200
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        insn_ready,
  output logic        insn_valid,
  output logic        insn_compressed,
  output logic [31:0] insn_out,
  output logic [31:0] insn_pc,
  generic_bus_if.cpu  icache
);

  localparam int PW = $clog2(DEPTH_HW);
  localparam int CW = PW + 1;

  logic [15:0]   mem [DEPTH_HW];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [31:0]   fetch_addr;
  logic [31:0]   req_addr;
  logic [31:0]   head_pc;
  logic          skip_low;
  logic          req_pending;
  logic          discard;

  logic [15:0]   h0;
  logic [15:0]   h1;
  logic          is_comp;
  logic          avail;
  logic          pop;
  logic [CW-1:0] pop_hw;
  logic [CW-1:0] push_hw;
  logic [CW:0]   demand;
  logic          accept;
  logic          do_push;
  logic          unused_bits;

  assign unused_bits = redirect_pc[0];

  assign h0      = mem[rd_ptr];
  assign h1      = mem[rd_ptr + PW'(1)];
  assign is_comp = (h0[1:0] != 2'b11);
  assign avail   = is_comp ? (count >= CW'(1)) : (count >= CW'(2));

  // A redirect cycle never presents an instruction, so no pop can race the flush.
  assign insn_valid      = avail && !redirect;
  assign insn_compressed = insn_valid && is_comp;
  assign insn_out        = !insn_valid ? 32'h0 : (is_comp ? {16'h0, h0} : {h1, h0});
  assign insn_pc         = head_pc;

  assign pop    = insn_valid && insn_ready;
  assign pop_hw = !pop ? CW'(0) : (is_comp ? CW'(1) : CW'(2));

  // Free-slot test counts pops against the budget, which keeps it conservative.
  assign demand = {1'b0, count} + {1'b0, pop_hw} + (CW+1)'(2);

  assign icache.ren     = nRST && (req_pending || (demand <= (CW+1)'(DEPTH_HW)));
  assign icache.addr    = req_pending ? req_addr : fetch_addr;
  assign icache.wen     = 1'b0;
  assign icache.wdata   = 32'h0;
  assign icache.byte_en = 4'hF;

  assign accept  = icache.ren && !icache.busy;
  assign do_push = accept && !discard && !redirect;
  assign push_hw = !do_push ? CW'(0) : (skip_low ? CW'(1) : CW'(2));

  always_ff @(posedge CLK) begin
    if (do_push) begin
      if (skip_low) begin
        mem[wr_ptr] <= icache.rdata[31:16];
      end else begin
        mem[wr_ptr]          <= icache.rdata[15:0];
        mem[wr_ptr + PW'(1)] <= icache.rdata[31:16];
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      fetch_addr  <= {RESET_PC[31:2], 2'b00};
      req_addr    <= {RESET_PC[31:2], 2'b00};
      head_pc     <= RESET_PC;
      skip_low    <= RESET_PC[1];
      req_pending <= 1'b0;
      discard     <= 1'b0;
    end else begin
      req_pending <= icache.ren && icache.busy;
      if (icache.ren && icache.busy && !req_pending) begin
        req_addr <= fetch_addr;
      end

      if (redirect) begin
        rd_ptr     <= '0;
        wr_ptr     <= '0;
        count      <= '0;
        head_pc    <= {redirect_pc[31:1], 1'b0};
        fetch_addr <= {redirect_pc[31:2], 2'b00};
        skip_low   <= redirect_pc[1];
        // A stalled request still completes on the old address; drop its data.
        discard    <= icache.ren && icache.busy;
      end else begin
        rd_ptr  <= rd_ptr + PW'(pop_hw);
        wr_ptr  <= wr_ptr + PW'(push_hw);
        count   <= count - pop_hw + push_hw;
        head_pc <= head_pc + {{(31-CW){1'b0}}, pop_hw, 1'b0};
        if (accept) begin
          discard <= 1'b0;
          if (!discard) begin
            fetch_addr <= fetch_addr + 32'd4;
          end
        end
        if (do_push && skip_low) begin
          skip_low <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: vector table for the first cycles after reset,
// then hand-written sequences for fill/drain, redirect-while-busy and mid-stream reset.
module tb_fetch_queue;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        insn_ready = 1'b0;
  logic        insn_valid;
  logic        insn_compressed;
  logic [31:0] insn_out;
  logic [31:0] insn_pc;

  int checks = 0;
  int errors = 0;

  generic_bus_if bus ();

  fetch_queue #(.DEPTH_HW(8), .RESET_PC(32'h0000_0200)) dut (
    .CLK             (CLK),
    .nRST            (nRST),
    .redirect        (redirect),
    .redirect_pc     (redirect_pc),
    .insn_ready      (insn_ready),
    .insn_valid      (insn_valid),
    .insn_compressed (insn_compressed),
    .insn_out        (insn_out),
    .insn_pc         (insn_pc),
    .icache          (bus)
  );

  always #5 CLK = ~CLK;

  // Fixed program words; every other address returns two compressed halfwords tagged by address.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    case (a)
      32'h0000_0200: word_at = 32'h00A0_0093;
      32'h0000_0204: word_at = 32'h4505_4585;
      32'h0000_0208: word_at = 32'h0013_0001;
      32'h0000_020C: word_at = 32'h4501_0000;
      32'h0000_1000: word_at = 32'h0093_4501;
      32'h0000_1004: word_at = 32'h0000_00A0;
      default:       word_at = {a[15:2], 2'b10, a[15:2], 2'b01};
    endcase
  endfunction

  function automatic logic [31:0] hw_at(input logic [31:0] p);
    hw_at = {16'h0, p[15:2], (p[1] ? 2'b10 : 2'b01)};
  endfunction

  assign bus.rdata = word_at(bus.addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        redir;
    logic [31:0] rpc;
    logic        busy;
    logic        e_ren;
    logic [31:0] e_addr;
    logic        e_valid;
    logic        e_comp;
    logic [31:0] e_out;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vecs[12];

  initial begin
    logic [31:0] exp_pc;
    int n;

    vecs[0]  = '{1'b0, 32'h0,    1'b0, 1'b1, 32'h200,  1'b0, 1'b0, 32'h0,        32'h200};
    vecs[1]  = '{1'b0, 32'h0,    1'b0, 1'b1, 32'h204,  1'b1, 1'b0, 32'h00A00093, 32'h200};
    vecs[2]  = '{1'b0, 32'h0,    1'b0, 1'b1, 32'h208,  1'b1, 1'b1, 32'h00004585, 32'h204};
    vecs[3]  = '{1'b0, 32'h0,    1'b1, 1'b1, 32'h20C,  1'b1, 1'b1, 32'h00004505, 32'h206};
    vecs[4]  = '{1'b0, 32'h0,    1'b1, 1'b1, 32'h20C,  1'b1, 1'b1, 32'h00000001, 32'h208};
    vecs[5]  = '{1'b0, 32'h0,    1'b1, 1'b1, 32'h20C,  1'b0, 1'b0, 32'h0,        32'h20A};
    vecs[6]  = '{1'b0, 32'h0,    1'b0, 1'b1, 32'h20C,  1'b0, 1'b0, 32'h0,        32'h20A};
    vecs[7]  = '{1'b0, 32'h0,    1'b0, 1'b1, 32'h210,  1'b1, 1'b0, 32'h00000013, 32'h20A};
    vecs[8]  = '{1'b1, 32'h1002, 1'b0, 1'b1, 32'h214,  1'b0, 1'b0, 32'h0,        32'h20E};
    vecs[9]  = '{1'b0, 32'h0,    1'b0, 1'b1, 32'h1000, 1'b0, 1'b0, 32'h0,        32'h1002};
    vecs[10] = '{1'b0, 32'h0,    1'b0, 1'b1, 32'h1004, 1'b0, 1'b0, 32'h0,        32'h1002};
    vecs[11] = '{1'b0, 32'h0,    1'b0, 1'b1, 32'h1008, 1'b1, 1'b0, 32'h00A00093, 32'h1002};

    bus.busy = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("reset_valid", {31'h0, insn_valid}, 32'h0);
    check("reset_comp",  {31'h0, insn_compressed}, 32'h0);
    check("reset_out",   insn_out, 32'h0);
    check("reset_pc",    insn_pc, 32'h200);
    check("reset_ren",   {31'h0, bus.ren}, 32'h0);
    $display("reset: valid=%b ren=%b pc=%h", insn_valid, bus.ren, insn_pc);

    @(posedge CLK); #1;
    nRST = 1'b1;
    insn_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      redirect    = vecs[i].redir;
      redirect_pc = vecs[i].rpc;
      bus.busy    = vecs[i].busy;
      @(negedge CLK);
      check($sformatf("v%0d_ren", i),   {31'h0, bus.ren}, {31'h0, vecs[i].e_ren});
      check($sformatf("v%0d_addr", i),  bus.addr, vecs[i].e_addr);
      check($sformatf("v%0d_valid", i), {31'h0, insn_valid}, {31'h0, vecs[i].e_valid});
      check($sformatf("v%0d_comp", i),  {31'h0, insn_compressed}, {31'h0, vecs[i].e_comp});
      check($sformatf("v%0d_out", i),   insn_out, vecs[i].e_out);
      check($sformatf("v%0d_pc", i),    insn_pc, vecs[i].e_pc);
      $display("vec %0d: ren=%b addr=%h valid=%b out=%h pc=%h", i, bus.ren, bus.addr, insn_valid, insn_out, insn_pc);
      @(posedge CLK); #1;
    end

    // Fill with decode stalled, then drain and confirm in-order delivery.
    insn_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h2000; bus.busy = 1'b0;
    @(posedge CLK); #1;
    redirect = 1'b0;
    repeat (20) @(posedge CLK);
    #1;
    @(negedge CLK);
    check("fill_ren",   {31'h0, bus.ren}, 32'h0);
    check("fill_valid", {31'h0, insn_valid}, 32'h1);
    check("fill_pc",    insn_pc, 32'h2000);
    check("fill_out",   insn_out, hw_at(32'h2000));
    $display("fill: ren=%b valid=%b pc=%h out=%h", bus.ren, insn_valid, insn_pc, insn_out);
    @(posedge CLK); #1;
    insn_ready = 1'b1;
    exp_pc = 32'h2000;
    n = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge CLK);
      if (insn_valid) begin
        check("drain_pc",   insn_pc, exp_pc);
        check("drain_out",  insn_out, hw_at(exp_pc));
        check("drain_comp", {31'h0, insn_compressed}, 32'h1);
        $display("drain: pc=%h out=%h", insn_pc, insn_out);
        exp_pc = exp_pc + 32'd2;
        n++;
      end
      @(posedge CLK); #1;
    end
    check("drain_count", n, 40);

    // Redirect while the I$ stalls: old address held, its data discarded.
    insn_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h3000; bus.busy = 1'b0;
    @(posedge CLK); #1;
    redirect = 1'b0; bus.busy = 1'b1;
    @(negedge CLK);
    check("busy_issue_ren",  {31'h0, bus.ren}, 32'h1);
    check("busy_issue_addr", bus.addr, 32'h3000);
    $display("busy: ren=%b addr=%h", bus.ren, bus.addr);
    @(posedge CLK); #1;
    redirect = 1'b1; redirect_pc = 32'h4002;
    @(negedge CLK);
    check("busy_redir_addr",  bus.addr, 32'h3000);
    check("busy_redir_valid", {31'h0, insn_valid}, 32'h0);
    $display("busy redirect: addr=%h valid=%b", bus.addr, insn_valid);
    @(posedge CLK); #1;
    redirect = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge CLK);
      check("busy_hold_addr",  bus.addr, 32'h3000);
      check("busy_hold_valid", {31'h0, insn_valid}, 32'h0);
      $display("busy hold: addr=%h valid=%b", bus.addr, insn_valid);
      @(posedge CLK); #1;
    end
    bus.busy = 1'b0;
    @(negedge CLK);
    check("discard_ren",   {31'h0, bus.ren}, 32'h1);
    check("discard_addr",  bus.addr, 32'h3000);
    check("discard_valid", {31'h0, insn_valid}, 32'h0);
    $display("discard: ren=%b addr=%h valid=%b", bus.ren, bus.addr, insn_valid);
    @(posedge CLK); #1;
    @(negedge CLK);
    check("newfetch_ren",   {31'h0, bus.ren}, 32'h1);
    check("newfetch_addr",  bus.addr, 32'h4000);
    check("newfetch_valid", {31'h0, insn_valid}, 32'h0);
    $display("new fetch: ren=%b addr=%h valid=%b", bus.ren, bus.addr, insn_valid);
    @(posedge CLK); #1;
    @(negedge CLK);
    check("redir_valid", {31'h0, insn_valid}, 32'h1);
    check("redir_comp",  {31'h0, insn_compressed}, 32'h1);
    check("redir_out",   insn_out, 32'h0000_4002);
    check("redir_pc",    insn_pc, 32'h4002);
    $display("after redirect: valid=%b out=%h pc=%h", insn_valid, insn_out, insn_pc);

    // Let the queue reach five halfwords, then reset asynchronously mid-request.
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    bus.busy = 1'b1;
    @(negedge CLK);
    check("pre_reset_valid", {31'h0, insn_valid}, 32'h1);
    check("pre_reset_ren",   {31'h0, bus.ren}, 32'h1);
    #2;
    nRST = 1'b0;
    #1;
    check("midreset_valid", {31'h0, insn_valid}, 32'h0);
    check("midreset_ren",   {31'h0, bus.ren}, 32'h0);
    check("midreset_pc",    insn_pc, 32'h200);
    $display("mid reset: valid=%b ren=%b pc=%h", insn_valid, bus.ren, insn_pc);
    @(posedge CLK); #1;
    bus.busy = 1'b0;
    nRST = 1'b1;
    @(negedge CLK);
    check("restart_ren",   {31'h0, bus.ren}, 32'h1);
    check("restart_addr",  bus.addr, 32'h200);
    check("restart_valid", {31'h0, insn_valid}, 32'h0);
    $display("restart: ren=%b addr=%h", bus.ren, bus.addr);
    @(posedge CLK); #1;
    @(negedge CLK);
    check("restart_insn_valid", {31'h0, insn_valid}, 32'h1);
    check("restart_insn_out",   insn_out, 32'h00A00093);
    check("restart_insn_pc",    insn_pc, 32'h200);
    $display("restart insn: valid=%b out=%h pc=%h", insn_valid, insn_out, insn_pc);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
